// File: rtl/frame_pkg.sv
// Shared defaults and state encoding for the frame-store read controller.
package frame_pkg;

    localparam int DATA_W_DEF    = 12;
    localparam int ADDR_W_DEF    = 10;
    localparam int RAM_DEPTH_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        SWAP  = 2'd3
    } state_e;

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry FIFO between the buffer read-return path and the output stream.
// Entry 0 is always the head, so the head stays stable until it is popped.
module skid_buffer2 #(
    parameter int WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] e0_q, e0_d;
    logic [WIDTH-1:0] e1_q, e1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             pop_eff;

    assign pop_eff = pop_i && (cnt_q != 2'd0);

    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        case ({push_i, pop_eff})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = din_i;
                else               e1_d = din_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    e0_d = din_i;
                end else begin
                    e0_d = e1_q;
                    e1_d = din_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the two entries are cleared as well, so the stream data reads 0 straight after reset.
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = e0_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/frame_reader.sv
// Scans the front buffer of the frame store, streams each word over valid/ready,
// and requests the buffer swap at frame boundaries once the writer has flagged one.
module frame_reader
    import frame_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int RAM_DEPTH  = RAM_DEPTH_DEF,
    parameter int CONTINUOUS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              frame_ready,
    output logic              buf_en,
    output logic              buf_swap_en,
    output logic [ADDR_W-1:0] buf_addr,
    input  logic [DATA_W-1:0] buf_dout,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              swapped
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              inflight_q, inflight_last_q;
    logic              pend_swap_q, swapped_q;

    logic              issue, swap_issue, pop, at_last_addr;
    logic [1:0]        occ;
    logic [DATA_W:0]   head;

    skid_buffer2 #(.WIDTH(DATA_W + 1)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .din_i   ({inflight_last_q, buf_dout}),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (occ)
    );

    assign out_valid    = (occ != 2'd0);
    assign out_data     = out_valid ? head[DATA_W-1:0] : '0;
    assign out_last     = out_valid & head[DATA_W];
    assign pop          = out_valid & out_ready;
    assign at_last_addr = (addr_q == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (issue && at_last_addr) state_d = DRAIN;
            DRAIN:   if (pop && head[DATA_W]) state_d = SWAP;
            SWAP:    state_d = (CONTINUOUS != 0) ? SCAN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reads keep held + in-flight words at two or fewer, counting this cycle's pop.
    always_comb begin
        issue       = 1'b0;
        swap_issue  = 1'b0;
        buf_en      = 1'b0;
        buf_swap_en = 1'b0;
        busy        = (state_q != IDLE);
        case (state_q)
            SCAN: begin
                issue  = ({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
                buf_en = issue;
            end
            SWAP: begin
                swap_issue  = pend_swap_q | frame_ready;
                buf_en      = swap_issue;
                buf_swap_en = swap_issue;
            end
            default: ;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        if (state_q != SCAN)  addr_d = '0;
        else if (issue)       addr_d = at_last_addr ? '0 : addr_q + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            pend_swap_q     <= 1'b0;
            swapped_q       <= 1'b0;
        end else begin
            addr_q          <= addr_d;
            inflight_q      <= issue;
            inflight_last_q <= issue & at_last_addr;
            pend_swap_q     <= swap_issue ? 1'b0 : (pend_swap_q | frame_ready);
            swapped_q       <= swap_issue;
        end
    end

    assign buf_addr = addr_q;
    assign swapped  = swapped_q;

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader with an 8-word double-buffered store model.
module tb_frame_reader;

    localparam int DW    = 12;
    localparam int AW    = 10;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, frame_ready, out_ready;
    logic          buf_en, buf_swap_en, out_valid, out_last, busy, swapped;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_dout, out_data;

    logic          start_nc;
    logic          out_ready_nc = 1'b1;
    logic          frame_ready_nc = 1'b0;
    logic          buf_en_nc, buf_swap_en_nc, out_valid_nc, out_last_nc, busy_nc, swapped_nc;
    logic [AW-1:0] buf_addr_nc;
    logic [DW-1:0] buf_dout_nc, out_data_nc;

    frame_reader #(.DATA_W(DW), .ADDR_W(AW), .RAM_DEPTH(DEPTH), .CONTINUOUS(1)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_ready(frame_ready),
        .buf_en(buf_en), .buf_swap_en(buf_swap_en), .buf_addr(buf_addr), .buf_dout(buf_dout),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .busy(busy), .swapped(swapped)
    );

    frame_reader #(.DATA_W(DW), .ADDR_W(AW), .RAM_DEPTH(DEPTH), .CONTINUOUS(0)) dut_nc (
        .clk(clk), .rst(rst), .start(start_nc), .frame_ready(frame_ready_nc),
        .buf_en(buf_en_nc), .buf_swap_en(buf_swap_en_nc), .buf_addr(buf_addr_nc), .buf_dout(buf_dout_nc),
        .out_data(out_data_nc), .out_valid(out_valid_nc), .out_ready(out_ready_nc), .out_last(out_last_nc),
        .busy(busy_nc), .swapped(swapped_nc)
    );

    // Store model: bank 0 holds 0x100+i, bank 1 holds 0x200+i.
    logic [DW-1:0] mem [0:1][0:DEPTH-1];
    logic          front = 1'b0;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[0][i] = DW'(12'h100 + i);
            mem[1][i] = DW'(12'h200 + i);
        end
    end

    always @(posedge clk) begin
        if (buf_en && !buf_swap_en) buf_dout <= mem[front][buf_addr[2:0]];
        if (buf_en && buf_swap_en)  front <= ~front;
        if (buf_en_nc && !buf_swap_en_nc) buf_dout_nc <= mem[0][buf_addr_nc[2:0]];
    end

    int checks = 0;
    int failures = 0;
    int outstanding = 0;
    int max_outstanding = 0;
    int stall_viol = 0;
    int swap_count = 0;
    int swap_bad = 0;
    bit toggle_mode = 1'b0;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    // Protocol watch on the opposite edge: outstanding words, stall stability, swap shape.
    always @(negedge clk) begin
        if (rst) begin
            outstanding = 0;
            stall_prev  = 1'b0;
        end else begin
            outstanding = outstanding + int'(buf_en && !buf_swap_en) - int'(out_valid && out_ready);
            if (outstanding > max_outstanding) max_outstanding = outstanding;
            if (stall_prev && (!out_valid || out_data !== prev_data || out_last !== prev_last))
                stall_viol++;
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (buf_swap_en) begin
                swap_count++;
                if (!buf_en) swap_bad++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " out_valid"}, out_valid, 0);
        check({tag, " out_data"}, out_data, 0);
        check({tag, " out_last"}, out_last, 0);
        check({tag, " buf_en"}, buf_en, 0);
        check({tag, " buf_swap_en"}, buf_swap_en, 0);
        check({tag, " buf_addr"}, buf_addr, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " swapped"}, swapped, 0);
    endtask

    task automatic take_word(input string tag, input logic [DW-1:0] exp_data,
                             input logic exp_last, input bit fr_on_hs);
        bit got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            if (toggle_mode) begin
                out_ready = ~out_ready;
                #1;
            end
            if (out_valid && out_ready) begin
                got = 1'b1;
                check({tag, " data"}, out_data, exp_data);
                check({tag, " last"}, out_last, exp_last);
                check({tag, " busy"}, busy, 1);
                if (fr_on_hs) frame_ready = 1'b1;
            end
            tick();
            frame_ready = 1'b0;
        end
        if (!got) check({tag, " timeout"}, 0, 1);
    endtask

    task automatic run_frame(input string tag, input logic [DW-1:0] base, input int fr_word);
        for (int i = 0; i < DEPTH; i++)
            take_word($sformatf("%s w%0d", tag, i), base + DW'(i), i == DEPTH - 1, i == fr_word);
    endtask

    // Entered in the SWAP cycle, right after the out_last handshake edge.
    task automatic boundary(input string tag, input bit exp_swap, input bit fr_in_swap,
                            input logic [DW-1:0] next_base);
        check({tag, " swap-cycle out_valid"}, out_valid, 0);
        check({tag, " swap-cycle busy"}, busy, 1);
        if (fr_in_swap) begin
            frame_ready = 1'b1;
            #1;
        end
        check({tag, " buf_swap_en"}, buf_swap_en, 32'(exp_swap));
        check({tag, " swap buf_en"}, buf_en, 32'(exp_swap));
        tick();
        frame_ready = 1'b0;
        check({tag, " swapped"}, swapped, 32'(exp_swap));
        check({tag, " refill buf_swap_en"}, buf_swap_en, 0);
        check({tag, " refill buf_en"}, buf_en, 1);
        check({tag, " refill buf_addr"}, buf_addr, 0);
        tick();
        check({tag, " refill2 out_valid"}, out_valid, 0);
        check({tag, " refill2 swapped"}, swapped, 0);
        tick();
        check({tag, " first out_valid"}, out_valid, 1);
        check({tag, " first out_data"}, out_data, 32'(next_base));
    endtask

    task automatic start_frame(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " T+1 buf_en"}, buf_en, 1);
        check({tag, " T+1 buf_addr"}, buf_addr, 0);
        check({tag, " T+1 busy"}, busy, 1);
        check({tag, " T+1 out_valid"}, out_valid, 0);
        tick();
        check({tag, " T+2 out_valid"}, out_valid, 0);
        tick();
        check({tag, " T+3 out_valid"}, out_valid, 1);
        check({tag, " T+3 out_data"}, out_data, 32'h100);
    endtask

    initial begin
        int got_nc;
        int en_nc;
        rst = 1'b1; start = 1'b0; frame_ready = 1'b0; out_ready = 1'b1; start_nc = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) tick();
        check("idle buf_en", buf_en, 0);
        check("idle busy", busy, 0);

        // Basic scan, then a boundary without a pending swap.
        start_frame("f1");
        run_frame("f1", 12'h100, -1);
        boundary("b1", 1'b0, 1'b0, 12'h100);

        // Backpressure: stall after word 3, then toggle ready.
        for (int i = 0; i < 4; i++)
            take_word($sformatf("bp w%0d", i), DW'(12'h100 + i), 1'b0, 1'b0);
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            check($sformatf("stall%0d out_valid", n), out_valid, 1);
            check($sformatf("stall%0d out_data", n), out_data, 32'h104);
            tick();
        end
        toggle_mode = 1'b1;
        for (int i = 4; i < DEPTH; i++)
            take_word($sformatf("bp w%0d", i), DW'(12'h100 + i), i == DEPTH - 1, 1'b0);
        toggle_mode = 1'b0;
        out_ready = 1'b1;
        boundary("b2", 1'b0, 1'b0, 12'h100);

        // Mid-frame reset with a swap pending.
        for (int i = 0; i < 4; i++)
            take_word($sformatf("rs w%0d", i), DW'(12'h100 + i), 1'b0, i == 1);
        rst = 1'b1;
        tick();
        check_all_zero("midreset");
        rst = 1'b0;
        repeat (4) tick();
        check("post-reset buf_en", buf_en, 0);
        check("post-reset busy", busy, 0);
        check("post-reset swaps", swap_count, 0);

        // Restart; start held high mid-frame must be ignored; the cleared swap must not fire.
        start_frame("fA");
        start = 1'b1;
        run_frame("fA", 12'h100, -1);
        start = 1'b0;
        boundary("bA", 1'b0, 1'b0, 12'h100);
        run_frame("fB", 12'h100, 2);
        boundary("bB", 1'b1, 1'b0, 12'h200);
        run_frame("fC", 12'h200, DEPTH - 1);
        boundary("bC", 1'b1, 1'b0, 12'h100);
        run_frame("fD", 12'h100, -1);
        boundary("bD", 1'b1, 1'b1, 12'h200);
        run_frame("fE", 12'h200, -1);

        check("swap count", swap_count, 3);
        check("swap without buf_en", swap_bad, 0);
        check("stall stability", stall_viol, 0);
        check("max outstanding", max_outstanding, 2);

        // Single-shot instance: one frame, then back to idle.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        start_nc = 1'b1;
        tick();
        start_nc = 1'b0;
        got_nc = 0;
        for (int n = 0; n < 40 && got_nc < DEPTH; n++) begin
            if (out_valid_nc) begin
                check($sformatf("nc w%0d data", got_nc), out_data_nc, 32'(12'h100 + got_nc));
                check($sformatf("nc w%0d last", got_nc), out_last_nc, 32'(got_nc == DEPTH - 1));
                got_nc++;
            end
            tick();
        end
        check("nc words", got_nc, DEPTH);
        check("nc swap-cycle busy", busy_nc, 1);
        tick();
        check("nc idle busy", busy_nc, 0);
        en_nc = 0;
        for (int n = 0; n < 20; n++) begin
            if (buf_en_nc) en_nc++;
            tick();
        end
        check("nc no buf_en after frame", en_nc, 0);
        check("nc out_valid idle", out_valid_nc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_reader.md
Name: frame_reader

Overview:
Read-side controller for the double-buffered frame store (`buffer`). It scans the front buffer sequentially from address 0 to RAM_DEPTH-1 and streams each word out over a valid/ready interface to the display driver. At each frame boundary, once all reads have drained, it issues the buffer swap if the writer has flagged a completed back buffer. It sits between `buffer` and the pixel/output pipeline.

Parameters:
DATA_W, 12, word width of the buffer data and the output stream
ADDR_W, 10, buffer address width
RAM_DEPTH, 1024, words per frame; must be ≤ 2**ADDR_W and ≥ 2
CONTINUOUS, 1, 1 = rescan automatically after each frame; 0 = return to IDLE after each frame

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  begin scanning; sampled only in IDLE
frame_ready  in  1  writer has completed the back buffer; one-cycle pulse or level
buf_en  out  1  buffer enable; high for each read and for the swap cycle
buf_swap_en  out  1  one-cycle swap request to the buffer
buf_addr  out  ADDR_W  buffer read address
buf_dout  in  DATA_W  buffer read data, valid 1 cycle after the address edge
out_data  out  DATA_W  stream data
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_last  out  1  marks word RAM_DEPTH-1 of the frame
busy  out  1  high outside IDLE
swapped  out  1  one-cycle pulse on the cycle after buf_swap_en

Behaviour:
- Reset: all outputs return to 0 on the next edge. This covers out_valid, out_data, out_last, buf_en, buf_swap_en, buf_addr, busy and swapped.
- Reset: state goes to IDLE, the skid buffer empties, the in-flight read is discarded and pend_swap clears.
- Buffer contract: a read is buf_en=1 with buf_swap_en=0; buf_dout is valid exactly 1 cycle later.
- Buffer contract: a swap is buf_en=1 with buf_swap_en=1 for exactly one cycle, and the new front buffer is in effect from the next cycle.
- Buffer contract: a read is never issued in the same cycle as a swap.
- Handshake: a word transfers on any cycle with out_valid & out_ready.
- Handshake: once out_valid is asserted, out_data and out_last stay stable until the transfer.
- Handshake: out_valid never drops without a transfer, except on rst.
- pend_swap: set by frame_ready in any state, including the cycle of the final handshake; cleared only when the swap is issued.
- IDLE: outputs idle. start=1 → SCAN with the address counter at 0.
- SCAN: issue a read when occupancy + inflight − pop < 2, where pop = out_valid & out_ready. This keeps at most 2 words held or in flight.
- SCAN: the address counter increments per issued read. After the read of RAM_DEPTH-1 is issued, go to DRAIN.
- DRAIN: no reads are issued. When the transfer carrying out_last completes, go to SWAP.
- SWAP (1 cycle): if pend_swap (including a frame_ready arriving this cycle), assert buf_swap_en and buf_en; swapped pulses on the next cycle.
- SWAP exit: CONTINUOUS=1 → SCAN at address 0; CONTINUOUS=0 → IDLE.
- Without pend_swap, the same front buffer is rescanned.
- Latency: with the start edge at T, the read of address 0 is issued in cycle T+1 and out_valid first rises after edge T+2.
- Throughput: 1 word/cycle with out_ready held at 1.
- Frame boundary with out_ready=1: one SWAP cycle plus 2 refill cycles before the next out_valid.
- Width: the address counter is ADDR_W bits, compared against RAM_DEPTH-1; wrap-around beyond RAM_DEPTH-1 never occurs.
- start outside IDLE: ignored.

Decomposition:
- Package frame_pkg: DATA_W/ADDR_W defaults and the state enum {IDLE, SCAN, DRAIN, SWAP}.
- Sub-module skid_buffer2: a 2-entry FIFO holding {data, last}, with push from the read-return path, pop on handshake, and an occupancy output.
- The top level holds the FSM, the address counter, the inflight flag and pend_swap.

Test Plan:
- Basic scan: RAM_DEPTH=8, front buffer preloaded with 0x100+i, out_ready=1, start at T → 0x100..0x107 in order, first out_valid after T+2, out_last only on 0x107, busy=1 throughout.
- Backpressure: out_ready low for 5 cycles after word 3, then toggling 1/0 → no loss or duplication, out_data held stable while stalled, never more than 2 reads outstanding.
- Swap: back buffer holds 0x200+i, frame_ready pulsed at word 2 → exactly one buf_swap_en+buf_en cycle after the 0x107 handshake, swapped pulses one cycle later, next frame streams 0x200..0x207.
- No swap and idle return: frame_ready never asserted, CONTINUOUS=1 → 0x100.. repeats with no buf_swap_en. CONTINUOUS=0 → after one frame, busy=0 and no further buf_en.
- Late frame_ready: frame_ready asserted on the cycle of the final handshake → swap issued at that boundary; frame_ready asserted on the SWAP cycle → swap also issued.
- Reset mid-frame: rst at word 4 with pend_swap set → all outputs 0 next cycle, no swap afterwards. A new start → stream restarts at 0x100 from address 0.
